// File: rtl/calc_pkg.sv
// Shared definitions for the keypad scanner: FSM state type, default timing
// constants and the key-index width helper.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam int DEF_ROWS          = 4;
  localparam int DEF_COLS          = 4;
  localparam int DEF_SCAN_DIV      = 4;
  localparam int DEF_DEBOUNCE      = 8;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_REPEAT_DELAY  = 64;
  localparam int DEF_REPEAT_PERIOD = 16;

  function automatic int key_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through key queue with sticky overflow and synchronous clear.
module key_fifo
  import calc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (i_push && !w_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr] <= i_data;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign o_data     = (r_count != '0) ? r_mem[r_rd] : '0;
  assign o_valid    = (r_count != '0);
  assign o_count    = r_count;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/keypad_scan_queue.sv
// Matrix keypad scanner: column sweep, press/release debounce, hold-to-repeat,
// and a FWFT queue of key indices (row*COLS+col).
module keypad_scan_queue
  import calc_pkg::*;
#(
  parameter int ROWS          = DEF_ROWS,
  parameter int COLS          = DEF_COLS,
  parameter int SCAN_DIV      = DEF_SCAN_DIV,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                              clk,
  input  logic                              RST,
  input  logic [ROWS-1:0]                   RowIn,
  output logic [COLS-1:0]                   ColOut,
  input  logic                              repeat_en,
  input  logic                              clear,
  output logic [key_width(ROWS, COLS)-1:0]  key_code,
  output logic                              key_valid,
  input  logic                              key_ready,
  output logic [$clog2(FIFO_DEPTH):0]       count,
  output logic                              overflow,
  output state_t                            o_dbg_state
);

  localparam int KW = key_width(ROWS, COLS);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + SCAN_DIV + DEBOUNCE + 1);

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [TW-1:0]   r_div;
  logic [TW-1:0]   r_deb;
  logic [TW-1:0]   r_rep;
  logic            r_rep_first;
  logic [ROWS-1:0] r_pat;
  logic [KW-1:0]   r_key;
  logic            r_push;
  logic [RW-1:0]   w_row;
  logic [KW-1:0]   w_key;
  logic [CW-1:0]   w_col_next;
  logic [TW-1:0]   w_rep_thr;

  always_comb begin
    w_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!RowIn[r]) w_row = RW'(r);
    end
  end

  assign w_key      = KW'(int'(w_row) * COLS + int'(r_col));
  assign w_col_next = (r_col == CW'(COLS - 1)) ? '0 : r_col + 1'b1;
  assign w_rep_thr  = r_rep_first ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_PERIOD - 1);

  // r_deb counts matching cycles in DEBOUNCE and all-high cycles in HELD.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state     <= ST_SCAN;
      r_col       <= '0;
      r_div       <= '0;
      r_deb       <= '0;
      r_rep       <= '0;
      r_rep_first <= 1'b1;
      r_pat       <= '1;
      r_key       <= '0;
      r_push      <= 1'b0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_div == TW'(SCAN_DIV - 1)) begin
            r_div <= '0;
            if (&RowIn) begin
              r_col <= w_col_next;
            end else begin
              r_state <= ST_DEBOUNCE;
              r_pat   <= RowIn;
              r_key   <= w_key;
              r_deb   <= '0;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (RowIn != r_pat) begin
            r_state <= ST_SCAN;
            r_div   <= '0;
          end else if (r_deb == TW'(DEBOUNCE - 1)) begin
            r_push      <= 1'b1;
            r_state     <= ST_HELD;
            r_deb       <= '0;
            r_rep       <= '0;
            r_rep_first <= 1'b1;
          end else begin
            r_deb <= r_deb + 1'b1;
          end
        end
        ST_HELD: begin
          if (&RowIn) begin
            if (r_deb == TW'(DEBOUNCE - 1)) begin
              r_state <= ST_RELEASE;
              r_deb   <= '0;
            end else begin
              r_deb <= r_deb + 1'b1;
            end
          end else begin
            r_deb <= '0;
            if (!repeat_en) begin
              r_rep       <= '0;
              r_rep_first <= 1'b1;
            end else if (r_rep == w_rep_thr) begin
              r_push      <= 1'b1;
              r_rep       <= '0;
              r_rep_first <= 1'b0;
            end else begin
              r_rep <= r_rep + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          r_state <= ST_SCAN;
          r_col   <= w_col_next;
          r_div   <= '0;
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign ColOut      = ~(COLS'(1) << r_col);
  assign o_dbg_state = r_state;

  // Pop handshake: an entry leaves on a rising edge where key_valid and
  // key_ready are both high; key_code is stable while key_valid is high.
  key_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (RST),
    .i_clear    (clear),
    .i_push     (r_push),
    .i_data     (r_key),
    .i_pop      (key_ready),
    .o_data     (key_code),
    .o_valid    (key_valid),
    .o_count    (count),
    .o_overflow (overflow)
  );

endmodule

// File: tb/tb_keypad_scan_queue.sv
// Directed and randomized bench for keypad_scan_queue with a keypad matrix
// model and an expected-queue scoreboard of key indices.
module tb_keypad_scan_queue;
  import calc_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KW    = 4;
  localparam int DEPTH = 4;
  localparam int HOLD_REPEAT = 64 + 3 * 16 + 8;
  localparam int REPEAT_PUSHES = 4;

  logic            clk;
  logic            RST;
  logic [ROWS-1:0] RowIn;
  logic [COLS-1:0] ColOut;
  logic            repeat_en;
  logic            clear;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_ready;
  logic [2:0]      count;
  logic            overflow;
  state_t          dbg_state;

  logic [ROWS*COLS-1:0] keys;
  logic [KW-1:0]        exp_q[$];
  logic                 mdl_ovf;
  logic                 rnd_rdy;
  int                   n_asserts;
  int                   n_fail;
  int                   n_pops;
  int                   pops_before;

  keypad_scan_queue dut (
    .clk         (clk),
    .RST         (RST),
    .RowIn       (RowIn),
    .ColOut      (ColOut),
    .repeat_en   (repeat_en),
    .clear       (clear),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .count       (count),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  // Clock and keypad matrix: a pressed key pulls its row low while its column is driven.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    RowIn = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (keys[r*COLS+c] && !ColOut[c]) RowIn[r] = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    logic [KW-1:0] e;
    if (key_valid === 1'b1 && key_ready === 1'b1) begin
      n_asserts++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL pop_unexpected: observed key %0d expected no entry", key_code);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_code", 32'(key_code), 32'(e));
      end
      n_pops++;
    end
  endtask

  task automatic step();
    sb_check();
    @(posedge clk);
    #1;
    if (rnd_rdy) key_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mdl_push(input int k);
    if (exp_q.size() < DEPTH) exp_q.push_back(KW'(k));
    else mdl_ovf = 1'b1;
  endtask

  task automatic wait_col(input int c);
    logic [COLS-1:0] want;
    int n;
    want = ~(COLS'(1) << c);
    n = 0;
    while (ColOut == want && n < 64) begin step(); n++; end
    while (ColOut != want && n < 128) begin step(); n++; end
    chk("wait_col", 32'(ColOut), 32'(want));
  endtask

  task automatic press(input int k, input int hold, input int settle);
    wait_col(k % COLS);
    keys[k] = 1'b1;
    steps(hold);
    keys[k] = 1'b0;
    steps(settle);
  endtask

  task automatic drain();
    key_ready = 1'b1;
    steps(DEPTH + 2);
    key_ready = 1'b0;
  endtask

  initial begin
    n_asserts = 0; n_fail = 0; n_pops = 0;
    keys = '0; key_ready = 1'b0; repeat_en = 1'b0; clear = 1'b0;
    mdl_ovf = 1'b0; rnd_rdy = 1'b0;
    RST = 1'b1;
    steps(3);
    chk("rst_colout", 32'(ColOut), 32'(4'b1110));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_valid", 32'(key_valid), 32'(0));
    chk("rst_code", 32'(key_code), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(ST_SCAN));
    RST = 1'b0;
    steps(2);

    // Single clean press of key 11, then a long idle with no extra push.
    mdl_push(11);
    press(11, 20, 20);
    chk("k11_count", 32'(count), 32'(exp_q.size()));
    chk("k11_code", 32'(key_code), 32'(11));
    chk("k11_valid", 32'(key_valid), 32'(1));
    steps(40);
    chk("k11_no_repush", 32'(count), 32'(1));
    drain();

    // Row 1 bouncing at column 2, then a stable press of key 6.
    wait_col(2);
    for (int i = 0; i < 10; i++) begin
      keys[6] = ~keys[6];
      steps(3);
    end
    keys[6] = 1'b0;
    steps(2);
    chk("bounce_no_push", 32'(count), 32'(0));
    mdl_push(6);
    press(6, 40, 20);
    chk("bounce_then_count", 32'(count), 32'(1));
    chk("bounce_then_code", 32'(key_code), 32'(6));
    drain();

    // Rows 0 and 3 together on column 1: lowest row wins.
    wait_col(1);
    keys[1] = 1'b1; keys[13] = 1'b1;
    mdl_push(1);
    steps(30);
    keys[1] = 1'b0; keys[13] = 1'b0;
    steps(20);
    chk("multi_count", 32'(count), 32'(1));
    chk("multi_code", 32'(key_code), 32'(1));
    drain();

    // Five presses into a four-deep queue with no pops.
    for (int i = 0; i < 5; i++) begin
      int k;
      k = (i == 0) ? 2 : (i == 1) ? 3 : (i == 2) ? 4 : (i == 3) ? 8 : 12;
      mdl_push(k);
      press(k, 30, 20);
    end
    chk("full_count", 32'(count), 32'(exp_q.size()));
    chk("full_ovf", 32'(overflow), 32'(mdl_ovf));
    drain();
    chk("drained_count", 32'(count), 32'(0));
    chk("ovf_sticky", 32'(overflow), 32'(1));
    mdl_push(9);
    press(9, 30, 20);
    chk("pre_clear_count", 32'(count), 32'(1));
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    mdl_ovf = 1'b0;
    chk("clear_count", 32'(count), 32'(0));
    chk("clear_ovf", 32'(overflow), 32'(0));
    chk("clear_valid", 32'(key_valid), 32'(0));

    // Hold-to-repeat on key 5, then the same hold with repeat disabled.
    key_ready = 1'b1;
    repeat_en = 1'b1;
    pops_before = n_pops;
    for (int i = 0; i < REPEAT_PUSHES; i++) mdl_push(5);
    press(5, HOLD_REPEAT, 20);
    chk("repeat_pops", 32'(n_pops - pops_before), 32'(REPEAT_PUSHES));
    chk("repeat_q_empty", 32'(exp_q.size()), 32'(0));
    repeat_en = 1'b0;
    pops_before = n_pops;
    mdl_push(5);
    press(5, HOLD_REPEAT, 20);
    chk("norepeat_pops", 32'(n_pops - pops_before), 32'(1));
    key_ready = 1'b0;

    // Reset pulse while key 7 is being debounced; the held key is re-accepted once.
    wait_col(3);
    keys[7] = 1'b1;
    steps(6);
    chk("pre_rst_state", 32'(dbg_state), 32'(ST_DEBOUNCE));
    #2 RST = 1'b1;
    #1;
    chk("midrst_colout", 32'(ColOut), 32'(4'b1110));
    chk("midrst_count", 32'(count), 32'(0));
    chk("midrst_state", 32'(dbg_state), 32'(ST_SCAN));
    exp_q.delete();
    mdl_ovf = 1'b0;
    steps(2);
    RST = 1'b0;
    mdl_push(7);
    steps(40);
    keys[7] = 1'b0;
    steps(20);
    chk("after_rst_count", 32'(count), 32'(1));
    chk("after_rst_code", 32'(key_code), 32'(7));
    drain();

    // Randomized presses with random key_ready, checked by the scoreboard.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int k;
      k = $urandom_range(0, ROWS * COLS - 1);
      mdl_push(k);
      keys[k] = 1'b1;
      steps($urandom_range(30, 45));
      keys[k] = 1'b0;
      steps($urandom_range(20, 30));
    end
    rnd_rdy = 1'b0;
    key_ready = 1'b1;
    steps(6);
    chk("rand_q_empty", 32'(exp_q.size()), 32'(0));
    chk("rand_valid", 32'(key_valid), 32'(0));
    chk("rand_ovf", 32'(overflow), 32'(mdl_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
